// File: rtl/count_checker.sv
// Lock-and-track checker for a free-running 32-bit counter.
// Counts mismatches once locked and flags counter restarts.
module count_checker #(
    parameter int unsigned LOCK_CNT   = 2,
    parameter int unsigned ERR_THRESH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] count,
    input  logic        count_vld,
    input  logic        clear,
    output logic        locked,
    output logic        err,
    output logic        restart,
    output logic [15:0] err_cnt,
    output logic [31:0] expected
);

    typedef enum logic [1:0] {
        UNLOCKED,
        SYNC,
        LOCKED
    } state_e;

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
    localparam logic [3:0] ERR_N  = 4'(ERR_THRESH);

    state_e      state_q, state_d;
    logic [31:0] exp_q, exp_d;
    logic [3:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        err_q, err_d;
    logic        restart_q, restart_d;
    logic        locked_q;

    logic [31:0] cnt_inc;
    logic [15:0] err_cnt_inc;
    logic        hit;

    assign cnt_inc     = count + 32'd1;
    assign hit         = (count == exp_q);
    assign err_cnt_inc = (err_cnt_q == 16'hFFFF) ? err_cnt_q
                                                 : err_cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        restart_d = 1'b0;
        if (clear) begin
            err_cnt_d = '0;
        end
        if (count_vld) begin
            unique case (state_q)
                UNLOCKED: begin
                    exp_d   = cnt_inc;
                    match_d = 4'd1;
                    miss_d  = '0;
                    state_d = (LOCK_N == 4'd1) ? LOCKED : SYNC;
                end
                SYNC: begin
                    if (hit) begin
                        exp_d   = exp_q + 32'd1;
                        match_d = match_q + 4'd1;
                        if (match_q + 4'd1 >= LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        exp_d   = cnt_inc;
                        match_d = 4'd1;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        exp_d  = exp_q + 32'd1;
                        miss_d = '0;
                    end else if (count == '0) begin
                        // counter wrapped back to zero early: restart, not error
                        restart_d = 1'b1;
                        exp_d     = 32'd1;
                        miss_d    = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = clear ? 16'd1 : err_cnt_inc;
                        exp_d     = cnt_inc;
                        if (miss_q + 4'd1 >= ERR_N) begin
                            state_d = UNLOCKED;
                            miss_d  = '0;
                            match_d = '0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= UNLOCKED;
            exp_q     <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            restart_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            restart_q <= restart_d;
            locked_q  <= (state_d == LOCKED);
        end
    end

    assign locked   = locked_q;
    assign err      = err_q;
    assign restart  = restart_q;
    assign err_cnt  = err_cnt_q;
    assign expected = exp_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed scoreboard bench for count_checker: lock, wrap, restart,
// error drop, reset, clear and err_cnt saturation.
module tb_count_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] count = '0;
    logic        count_vld = 1'b0;
    logic        clear = 1'b0;

    logic        locked_a, err_a, restart_a;
    logic [15:0] err_cnt_a;
    logic [31:0] expected_a;
    logic        locked_s, err_s, restart_s;
    logic [15:0] err_cnt_s;
    logic [31:0] expected_s;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        sel;
        logic        lk;
        logic        er;
        logic        rs;
        logic [15:0] ec;
        logic [31:0] ex;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    count_checker dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .count_vld(count_vld),
        .clear    (clear),
        .locked   (locked_a),
        .err      (err_a),
        .restart  (restart_a),
        .err_cnt  (err_cnt_a),
        .expected (expected_a)
    );

    // second instance shares stimulus; used for the saturation run
    count_checker #(
        .LOCK_CNT  (1),
        .ERR_THRESH(15)
    ) dut_s (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .count_vld(count_vld),
        .clear    (clear),
        .locked   (locked_s),
        .err      (err_s),
        .restart  (restart_s),
        .err_cnt  (err_cnt_s),
        .expected (expected_s)
    );

    function automatic exp_t mk(input logic s, lk, er, rs,
                                input logic [15:0] ec,
                                input logic [31:0] ex);
        exp_t e;
        e.sel = s;
        e.lk  = lk;
        e.er  = er;
        e.rs  = rs;
        e.ec  = ec;
        e.ex  = ex;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic compare();
        exp_t e;
        n_checks++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard: observed empty expected entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                chk("s_locked", 32'(locked_s), 32'(e.lk));
                chk("s_err", 32'(err_s), 32'(e.er));
                chk("s_restart", 32'(restart_s), 32'(e.rs));
                chk("s_err_cnt", 32'(err_cnt_s), 32'(e.ec));
                chk("s_expected", expected_s, e.ex);
            end else begin
                chk("locked", 32'(locked_a), 32'(e.lk));
                chk("err", 32'(err_a), 32'(e.er));
                chk("restart", 32'(restart_a), 32'(e.rs));
                chk("err_cnt", 32'(err_cnt_a), 32'(e.ec));
                chk("expected", expected_a, e.ex);
            end
        end
    endtask

    task automatic step(input logic r, v, input logic [31:0] c,
                        input logic cl, input exp_t e);
        rst       = r;
        count_vld = v;
        count     = c;
        clear     = cl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drv(input logic [31:0] c);
        rst       = 1'b0;
        count_vld = 1'b1;
        count     = c;
        clear     = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] e;
        int n;

        // reset and basic lock on 5,6,7,8
        step(1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
        step(0, 1, 5, 0, mk(0, 0, 0, 0, 0, 6));
        step(0, 1, 6, 0, mk(0, 1, 0, 0, 0, 7));
        step(0, 1, 7, 0, mk(0, 1, 0, 0, 0, 8));
        step(0, 1, 8, 0, mk(0, 1, 0, 0, 0, 9));
        step(0, 0, 32'hDEAD, 0, mk(0, 1, 0, 0, 0, 9));

        // one-cycle reset mid-run beats count_vld and clear
        step(0, 1, 9, 0, mk(0, 1, 0, 0, 0, 10));
        step(1, 1, 10, 1, mk(0, 0, 0, 0, 0, 0));
        step(0, 1, 32'hFFFF_FFFC, 0, mk(0, 0, 0, 0, 0, 32'hFFFF_FFFD));
        step(0, 1, 32'hFFFF_FFFD, 0, mk(0, 1, 0, 0, 0, 32'hFFFF_FFFE));

        // modulo-2^32 wrap is a match, not a restart
        step(0, 1, 32'hFFFF_FFFE, 0, mk(0, 1, 0, 0, 0, 32'hFFFF_FFFF));
        step(0, 1, 32'hFFFF_FFFF, 0, mk(0, 1, 0, 0, 0, 0));
        step(0, 1, 0, 0, mk(0, 1, 0, 0, 0, 1));
        step(0, 1, 1, 0, mk(0, 1, 0, 0, 0, 2));

        // advance to expected=0x20, then restart
        for (int i = 2; i < 32; i++) begin
            step(0, 1, 32'(i), 0, mk(0, 1, 0, 0, 0, 32'(i + 1)));
        end
        step(0, 1, 0, 0, mk(0, 1, 0, 1, 0, 1));
        step(0, 1, 1, 0, mk(0, 1, 0, 0, 0, 2));

        // three unrelated values drop lock
        step(0, 1, 32'h100, 0, mk(0, 1, 1, 0, 1, 32'h101));
        step(0, 1, 32'h300, 0, mk(0, 1, 1, 0, 2, 32'h301));
        step(0, 1, 32'h500, 0, mk(0, 0, 1, 0, 3, 32'h501));
        step(0, 0, 32'h777, 0, mk(0, 0, 0, 0, 3, 32'h501));

        // relock, then clear together with a counted mismatch
        step(0, 1, 32'h600, 0, mk(0, 0, 0, 0, 3, 32'h601));
        step(0, 1, 32'h601, 0, mk(0, 1, 0, 0, 3, 32'h602));
        step(0, 1, 32'h700, 1, mk(0, 1, 1, 0, 1, 32'h701));

        // saturation on the LOCK_CNT=1 / ERR_THRESH=15 instance
        step(1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0));
        step(0, 1, 32'h10, 0, mk(1, 1, 0, 0, 0, 32'h11));
        e = 32'h11;
        n = 0;
        while (n < 65535) begin
            for (int k = 0; k < 14 && n < 65535; k++) begin
                drv(e + 32'd5);
                e = e + 32'd6;
                n++;
            end
            drv(e);
            e = e + 32'd1;
        end
        step(0, 1, e, 0, mk(1, 1, 0, 0, 16'hFFFF, e + 32'd1));
        e = e + 32'd1;
        step(0, 1, e + 32'd5, 0, mk(1, 1, 1, 0, 16'hFFFF, e + 32'd6));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
